// File: rtl/dispatch_stage_8wide.sv
// dispatch_stage_8wide: single-entry, 8-slot staging register between rename
// and the issue queue. Tracks a physical-register busy scoreboard so each
// micro-op leaves with correct operand-ready bits, and folds in wakeup
// broadcasts that arrive while a group is waiting for issue-queue space.
module dispatch_stage_8wide #(
  parameter int NUM_PREGS   = 128,
  parameter int WIDTH       = 8,
  parameter int STALL_CNT_W = 32,
  parameter int TAG_W       = $clog2(NUM_PREGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic [WIDTH-1:0]                 in_valid_i,
  output logic                             in_ready_o,
  input  logic [WIDTH-1:0][2:0]            in_func_type_i,
  input  logic [WIDTH-1:0][63:0]           in_op1_i,
  input  logic [WIDTH-1:0][63:0]           in_op2_i,
  input  logic [WIDTH-1:0][63:0]           in_op3_i,
  input  logic [WIDTH-1:0][63:0]           in_pred_mask_i,
  input  logic [WIDTH-1:0][TAG_W-1:0]      in_src1_tag_i,
  input  logic [WIDTH-1:0][TAG_W-1:0]      in_src2_tag_i,
  input  logic [WIDTH-1:0][TAG_W-1:0]      in_src3_tag_i,
  input  logic [WIDTH-1:0][TAG_W-1:0]      in_dest_phys_i,
  input  logic [WIDTH-1:0][7:0]            in_rob_idx_i,
  input  logic [WIDTH-1:0]                 wakeup_valid_i,
  input  logic [WIDTH-1:0][TAG_W-1:0]      wakeup_tag_i,
  input  logic [WIDTH-1:0][63:0]           wakeup_data_i,
  input  logic                             iq_full_i,
  output logic [WIDTH-1:0]                 alloc_valid_o,
  output logic [WIDTH-1:0][2:0]            func_type_o,
  output logic [WIDTH-1:0][63:0]           op1_o,
  output logic [WIDTH-1:0][63:0]           op2_o,
  output logic [WIDTH-1:0][63:0]           op3_o,
  output logic [WIDTH-1:0][63:0]           pred_mask_o,
  output logic [WIDTH-1:0][TAG_W-1:0]      src1_tag_o,
  output logic [WIDTH-1:0][TAG_W-1:0]      src2_tag_o,
  output logic [WIDTH-1:0][TAG_W-1:0]      src3_tag_o,
  output logic [WIDTH-1:0][TAG_W-1:0]      dest_phys_o,
  output logic [WIDTH-1:0][7:0]            rob_idx_o,
  output logic [WIDTH-1:0]                 ready1_o,
  output logic [WIDTH-1:0]                 ready2_o,
  output logic [WIDTH-1:0]                 ready3_o,
  output logic [STALL_CNT_W-1:0]           stall_cnt_o
);

  // Held group state; the three sources are stored as a [source][slot] array.
  logic                               hold_valid_q;
  logic [WIDTH-1:0]                   slot_valid_q;
  logic [WIDTH-1:0][2:0]              func_q;
  logic [2:0][WIDTH-1:0][63:0]        op_q;
  logic [WIDTH-1:0][63:0]             pred_q;
  logic [2:0][WIDTH-1:0][TAG_W-1:0]   src_tag_q;
  logic [WIDTH-1:0][TAG_W-1:0]        dest_q;
  logic [WIDTH-1:0][7:0]              rob_q;
  logic [2:0][WIDTH-1:0]              rdy_q;
  logic [NUM_PREGS-1:0]               busy_q;
  logic [STALL_CNT_W-1:0]             stall_q;

  logic                               drain;
  logic                               accept;
  logic [2:0][WIDTH-1:0][TAG_W-1:0]   src_tag_in;
  logic [2:0][WIDTH-1:0][63:0]        op_in;
  logic [2:0][WIDTH-1:0]              acc_rdy;
  logic [2:0][WIDTH-1:0][63:0]        acc_op;
  logic [2:0][WIDTH-1:0]              held_rdy;
  logic [2:0][WIDTH-1:0][63:0]        held_op;
  logic [NUM_PREGS-1:0]               busy_set;
  logic [NUM_PREGS-1:0]               busy_clr;
  logic [NUM_PREGS-1:0]               busy_nxt;
  logic [STALL_CNT_W-1:0]             stall_nxt;

  // Returns {hit, data} for a tag against the wakeup lanes; the lowest
  // matching lane wins, so the scan runs from the top lane downward.
  function automatic logic [64:0] wake_lookup(
    input logic [TAG_W-1:0]            tag,
    input logic [WIDTH-1:0]            wv,
    input logic [WIDTH-1:0][TAG_W-1:0] wt,
    input logic [WIDTH-1:0][63:0]      wd
  );
    logic [64:0] r;
    r = {1'b0, 64'h0};
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (wv[k] && (wt[k] == tag)) begin
        r = {1'b1, wd[k]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign src_tag_in[0] = in_src1_tag_i;
  assign src_tag_in[1] = in_src2_tag_i;
  assign src_tag_in[2] = in_src3_tag_i;
  assign op_in[0]      = in_op1_i;
  assign op_in[1]      = in_op2_i;
  assign op_in[2]      = in_op3_i;

  assign drain         = hold_valid_q && !iq_full_i;
  assign in_ready_o    = !hold_valid_q || drain;
  assign accept        = in_ready_o && (|in_valid_i) && !flush_i;
  assign alloc_valid_o = slot_valid_q & {WIDTH{drain}};

  assign func_type_o = func_q;
  assign op1_o       = op_q[0];
  assign op2_o       = op_q[1];
  assign op3_o       = op_q[2];
  assign pred_mask_o = pred_q;
  assign src1_tag_o  = src_tag_q[0];
  assign src2_tag_o  = src_tag_q[1];
  assign src3_tag_o  = src_tag_q[2];
  assign dest_phys_o = dest_q;
  assign rob_idx_o   = rob_q;
  assign ready1_o    = rdy_q[0];
  assign ready2_o    = rdy_q[1];
  assign ready3_o    = rdy_q[2];
  assign stall_cnt_o = stall_q;

  // Operand readiness of an incoming group: p0, intra-group RAW, scoreboard, same-cycle wakeup.
  always_comb begin
    logic [TAG_W-1:0] tag_v;
    logic [64:0]      wk;
    logic             raw;
    acc_rdy = '0;
    acc_op  = op_in;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < WIDTH; j++) begin
        tag_v = src_tag_in[s][j];
        wk    = wake_lookup(tag_v, wakeup_valid_i, wakeup_tag_i, wakeup_data_i);
        raw   = 1'b0;
        for (int i = 0; i < j; i++) begin
          if (in_valid_i[i] && (in_dest_phys_i[i] == tag_v)) begin
            raw = 1'b1;
          end else begin
            raw = raw;
          end
        end
        if (tag_v == {TAG_W{1'b0}}) begin
          acc_rdy[s][j] = 1'b1;
        end else if (raw) begin
          acc_rdy[s][j] = 1'b0;
        end else if (!busy_q[tag_v]) begin
          acc_rdy[s][j] = 1'b1;
        end else if (wk[64]) begin
          acc_rdy[s][j] = 1'b1;
          acc_op[s][j]  = wk[63:0];
        end else begin
          acc_rdy[s][j] = 1'b0;
        end
      end
    end
  end

  // Wakeup capture for the held group: not-ready sources pick up broadcast data.
  always_comb begin
    logic [64:0] wk;
    held_rdy = rdy_q;
    held_op  = op_q;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < WIDTH; j++) begin
        wk = wake_lookup(src_tag_q[s][j], wakeup_valid_i, wakeup_tag_i, wakeup_data_i);
        if (!rdy_q[s][j] && wk[64]) begin
          held_rdy[s][j] = 1'b1;
          held_op[s][j]  = wk[63:0];
        end else begin
          held_rdy[s][j] = rdy_q[s][j];
        end
      end
    end
  end

  // Scoreboard next state: wakeups clear, accepted dests set, set wins, p0 never set.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (accept && in_valid_i[j] && (in_dest_phys_i[j] != {TAG_W{1'b0}})) begin
        busy_set[in_dest_phys_i[j]] = 1'b1;
      end else begin
        busy_set = busy_set;
      end
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (wakeup_valid_i[k]) begin
        busy_clr[wakeup_tag_i[k]] = 1'b1;
      end else begin
        busy_clr = busy_clr;
      end
    end
    busy_nxt = (busy_q & ~busy_clr) | busy_set;
  end

  // Saturating count of cycles a held group is blocked by a full issue queue.
  always_comb begin
    if (hold_valid_q && iq_full_i && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_nxt = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_nxt = stall_q;
    end
  end

  // Control and scoreboard registers; reset over flush, flush keeps the stall count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      slot_valid_q <= '0;
      busy_q       <= '0;
      stall_q      <= '0;
    end else if (flush_i) begin
      hold_valid_q <= 1'b0;
      slot_valid_q <= slot_valid_q;
      busy_q       <= '0;
      stall_q      <= stall_nxt;
    end else begin
      busy_q  <= busy_nxt;
      stall_q <= stall_nxt;
      if (accept) begin
        hold_valid_q <= 1'b1;
        slot_valid_q <= in_valid_i;
      end else if (drain) begin
        hold_valid_q <= 1'b0;
        slot_valid_q <= slot_valid_q;
      end else begin
        hold_valid_q <= hold_valid_q;
        slot_valid_q <= slot_valid_q;
      end
    end
  end

  // Hold-register payload: load on accept, otherwise fold in wakeups each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q    <= '0;
      op_q      <= '0;
      pred_q    <= '0;
      src_tag_q <= '0;
      dest_q    <= '0;
      rob_q     <= '0;
      rdy_q     <= '0;
    end else if (accept) begin
      func_q    <= in_func_type_i;
      op_q      <= acc_op;
      pred_q    <= in_pred_mask_i;
      src_tag_q <= src_tag_in;
      dest_q    <= in_dest_phys_i;
      rob_q     <= in_rob_idx_i;
      rdy_q     <= acc_rdy;
    end else begin
      op_q  <= held_op;
      rdy_q <= held_rdy;
    end
  end

endmodule

// File: doc/dispatch_stage_8wide.md
Name: dispatch_stage_8wide

Overview:
- Single-entry, 8-slot staging register between rename and the 8-wide issue queue.
- Holds a renamed group until the issue queue has room.
- Keeps a 128-entry physical-register busy scoreboard. Each micro-op's ready1/2/3 bits are therefore correct at allocation.
- Captures wakeup broadcasts while a group is held, so no wakeup is missed between rename and issue-queue entry.

Parameters:
- NUM_PREGS, 128, physical registers; tag width 7; p0 is hardwired ready.
- WIDTH, 8, slots per group.
- STALL_CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  squash held group and clear scoreboard
- in_valid_i  in  8  per-slot valid of the renamed group
- in_ready_o  out  1  group accepted when in_ready_o && |in_valid_i
- in_func_type_i  in  3x8  FU class
- in_op1_i/in_op2_i/in_op3_i  in  64x8  operand values; meaningful only if source not busy
- in_pred_mask_i  in  64x8  predicate mask
- in_src1_tag_i/in_src2_tag_i/in_src3_tag_i  in  7x8  source physical tags
- in_dest_phys_i  in  7x8  destination physical tag
- in_rob_idx_i  in  8x8  ROB index
- wakeup_valid_i  in  8  broadcast valids
- wakeup_tag_i  in  7x8  broadcast tags
- wakeup_data_i  in  64x8  broadcast data
- iq_full_i  in  1  issue-queue full
- alloc_valid_o  out  8  to issue queue
- func_type_o, op1_o, op2_o, op3_o, pred_mask_o, src1_tag_o, src2_tag_o, src3_tag_o, dest_phys_o, rob_idx_o  out  per slot, same widths as inputs
- ready1_o/ready2_o/ready3_o  out  8  operand-ready bits
- stall_cnt_o  out  32  saturating count of hold-blocked cycles

Behaviour:
- State: hold_valid_q; 8-slot hold register (fields plus rdy1..3); busy_q[127:0].
- Reset (rst_n=0 at clk edge):
  - hold_valid_q=0, all slot valids 0, busy_q=0, stall_cnt_o=0.
  - Outputs: alloc_valid_o=0, ready*_o=0, data outputs 0.
- alloc_valid_o = slot_valid_q & {8{hold_valid_q && !iq_full_i}}. Combinational from registers and iq_full_i.
- drain = hold_valid_q && !iq_full_i. The whole group leaves in one cycle; there are no partial drains.
- in_ready_o = !hold_valid_q || drain. Combinational; zero-bubble back-to-back groups are supported.
- Accept:
  - Latch all slots and set slot_valid_q=in_valid_i.
  - An all-zero in_valid_i is not an accept.
- Ready computation for source s of slot j at accept:
  - 1 if tag==0.
  - Else 0 if any valid slot i<j in the same group has dest==tag (intra-group RAW).
  - Else 1 if !busy_q[tag].
  - Else 1 if a same-cycle wakeup matches the tag; the operand is then taken from wakeup_data_i. Lowest wakeup lane wins on duplicate tags.
  - Else 0.
- Scoreboard:
  - On accept, set busy for each valid slot's dest!=0.
  - Each valid wakeup clears busy[tag].
  - Same-cycle set and clear of the same tag: set wins.
  - Tag 0 is never set.
- Held group:
  - Each cycle, any not-ready source matching a valid wakeup becomes ready and its operand takes the wakeup data (lowest lane wins).
  - This update happens in the same edge as drain. The issue queue sees pre-update values on the output cycle; the wakeup is also visible to the issue queue itself.
- stall_cnt_o increments when hold_valid_q && iq_full_i and saturates at all-ones.
- flush_i (rst_n=1):
  - Next cycle hold_valid_q=0 and busy_q=0.
  - An input offered in the flush cycle is dropped, even though in_ready_o may read 1.
  - stall_cnt_o is preserved.
- Reset mid-hold behaves the same as flush but also clears stall_cnt_o. Reset has priority over flush.

Test Plan:
- Reset, then a group with in_valid_i=8'hFF, all src tags 0, iq_full_i=0 -> alloc_valid_o=8'hFF one cycle after accept; all ready*=1; busy set for dests 1..8.
- Slot0 dest=5, slot3 src1=5, busy_q[5]=0 -> slot3 ready1_o=0; busy_q[5]=1 after accept.
- Held group with src2=9 not ready, iq_full_i=1 for 3 cycles, wakeup tag 9 data 64'hDEAD in cycle 2 -> ready2_o=1, op2_o=64'hDEAD; alloc_valid_o=0 until iq_full_i falls; stall_cnt_o=3.
- Accept with dest=12 and a same-cycle wakeup of tag 12 -> busy_q[12]=1 afterwards.
- Back-to-back groups with iq_full_i=0 -> in_ready_o stays 1; one group per cycle at output, no bubble.
- flush_i while holding with busy bits set -> next cycle alloc_valid_o=0, in_ready_o=1; a new group reading any prior dest tag shows ready=1.
